sc_bitstream_gen: RTL and testbench

SC_BITSTREAM_GEN -- requirements
Module: sc_bitstream_gen

---
 rtl/sc_bitstream_gen.sv | 159 +++++++++++++++
 tb/tb_sc_bitstream_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_bitstream_gen.sv
// Binary-to-stochastic encoder: turns one (N+1)-bit sample into a 2^N-bit
// unipolar bitstream whose count of ones equals the saturated sample value.
module sc_bitstream_gen #(
  parameter int unsigned    N    = 12,
  parameter logic [N-1:0]   SEED = {{(N-1){1'b0}}, 1'b1}
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [N:0] in_data,
  output logic       in_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       frame_first,
  output logic       frame_last
);

  // Primitive-polynomial feedback taps (bit k-1 set for tap k), N = 2..16.
  function automatic logic [31:0] taps_for(input int unsigned n);
    case (n)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_D008;
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam logic [N-1:0] TAPS    = N'(taps_for(N));
  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N:0]   FULL    = {1'b1, {N{1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] lfsr_q, lfsr_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N:0]   val_q, val_d;
  logic         bit_out_q, bit_out_d;
  logic         bit_valid_q, bit_valid_d;
  logic         first_q, first_d;
  logic         last_q, last_d;
  logic         in_ready_q, in_ready_d;

  logic         accept;
  logic         emit;
  logic         fb;
  logic [N-1:0] lfsr_next;
  logic [N:0]   sat_data;
  logic [N:0]   use_val;

  // De Bruijn-extended Fibonacci LFSR: inverting feedback when all but the
  // outgoing bit are zero splices the all-zero state into the sequence.
  always_comb begin
    fb        = (^(lfsr_q & TAPS)) ^ (lfsr_q[N-2:0] == '0);
    lfsr_next = {lfsr_q[N-2:0], fb};
  end

  // Next-state and next-output logic; a frame bit is emitted on every edge
  // that either accepts a sample or continues a frame in progress.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    val_d       = val_q;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    in_ready_d  = 1'b1;
    emit        = 1'b0;
    use_val     = val_q;
    accept      = in_valid & in_ready_q;
    sat_data    = in_data[N] ? FULL : in_data;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          val_d   = sat_data;
          use_val = sat_data;
          cnt_d   = '0;
          first_d = 1'b1;
          emit    = 1'b1;
        end
      end
      RUN: begin
        if (last_q) begin
          cnt_d = '0;
          if (accept) begin
            val_d   = sat_data;
            use_val = sat_data;
            first_d = 1'b1;
            emit    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + N'(1);
          emit  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (emit) begin
      bit_valid_d = 1'b1;
      bit_out_d   = ({1'b0, lfsr_q} < use_val);
      lfsr_d      = lfsr_next;
      last_d      = (cnt_d == CNT_MAX);
      in_ready_d  = last_d;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      cnt_q       <= '0;
      val_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      val_q       <= val_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_first = first_q;
  assign frame_last  = last_q;

endmodule

// File: tb/tb_sc_bitstream_gen.sv
// Bench for sc_bitstream_gen (N=12): stimulus pushes expected per-frame ones
// counts; a monitor measures each frame and compares against the queue.
`timescale 1ns/1ps
module tb_sc_bitstream_gen;

  localparam int unsigned N     = 12;
  localparam int          FRAME = 4096;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic [N:0]    in_data;
  logic          in_ready;
  logic          bit_out;
  logic          bit_valid;
  logic          frame_first;
  logic          frame_last;

  int n_tests = 0;
  int n_fail  = 0;
  int idle_err = 0;
  int exp_q[$];
  bit seen[FRAME];

  sc_bitstream_gen #(.N(N), .SEED(12'h001)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .frame_first (frame_first),
    .frame_last  (frame_last)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame monitor: measures length, ones and frame markers of every frame.
  initial begin : monitor
    int  pos;
    int  ones;
    bit  in_frame;
    bit  mark_err;
    int  e;
    pos = 0; ones = 0; in_frame = 0; mark_err = 0;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        in_frame = 0; pos = 0; ones = 0; mark_err = 0;
      end else if (bit_valid === 1'b1) begin
        if (!in_frame) begin
          in_frame = 1; pos = 0; ones = 0; mark_err = 0;
        end
        if (frame_first !== (pos == 0)) mark_err = 1;
        if (bit_out === 1'b1) ones++;
        if (frame_last === 1'b1) begin
          chk("frame_len", pos + 1, FRAME);
          chk("frame_markers", int'(mark_err), 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_ones", ones, e);
          end
          in_frame = 0;
        end
        pos++;
      end else begin
        if (in_frame) begin
          chk("frame_truncated", pos, FRAME);
          in_frame = 0;
        end
        if (bit_out !== 1'b0 || frame_first !== 1'b0 || frame_last !== 1'b0) idle_err++;
      end
    end
  end

  // Drive a sample for the next edge; caller is at a negedge.
  task automatic send(input int val, input int exp_ones);
    in_valid = 1'b1;
    in_data  = 13'(val);
    exp_q.push_back(exp_ones);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("lat_valid", int'(bit_valid), 1);
    chk("lat_first", int'(frame_first), 1);
  endtask

  task automatic wait_last(input string name);
    bit found;
    found = 0;
    for (int k = 0; k < FRAME + 200; k++) begin
      @(negedge clock);
      if (frame_last === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (!found) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic after_frame(input string name);
    @(posedge clock);
    #1;
    chk({name, "_idle_valid"}, int'(bit_valid), 0);
    chk({name, "_idle_ready"}, int'(in_ready), 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int distinct;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #12;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_valid", int'(bit_valid), 0);
    chk("rst_bit", int'(bit_out), 0);
    chk("rst_first", int'(frame_first), 0);
    chk("rst_last", int'(frame_last), 0);
    chk("rst_lfsr", int'(dut.lfsr_q), 1);

    // Accept on the very first edge after release; seed 1 then 3 vs value 3.
    @(negedge clock);
    reset_n = 1'b1;
    send(3, 3);
    chk("v3_bit0", int'(bit_out), 1);
    @(posedge clock);
    #1;
    chk("v3_bit1", int'(bit_out), 0);
    chk("v3_first_drop", int'(frame_first), 0);
    chk("mid_ready", int'(in_ready), 0);
    wait_last("v3");
    after_frame("v3");

    @(negedge clock); send(0, 0);       wait_last("v0");    after_frame("v0");
    @(negedge clock); send(4096, 4096); wait_last("v4096"); after_frame("v4096");
    @(negedge clock); send(8191, 4096); wait_last("v8191"); after_frame("v8191");

    // Back-to-back: 7 then 2055, with ignored data offered mid-frame.
    @(negedge clock);
    send(7, 7);
    in_valid = 1'b1;
    in_data  = 13'(999);
    repeat (4) begin
      @(negedge clock);
      chk("b2b_mid_ready", int'(in_ready), 0);
    end
    wait_last("b2b_a");
    chk("b2b_last_ready", int'(in_ready), 1);
    in_data = 13'(2055);
    exp_q.push_back(2055);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("b2b_contig_valid", int'(bit_valid), 1);
    chk("b2b_contig_first", int'(frame_first), 1);
    wait_last("b2b_b");
    after_frame("b2b");

    // Reset at bit 1000 of a frame, then restart from the seed.
    @(negedge clock);
    send(500, 500);
    repeat (1000) @(posedge clock);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mrst_valid", int'(bit_valid), 0);
    chk("mrst_bit", int'(bit_out), 0);
    chk("mrst_first", int'(frame_first), 0);
    chk("mrst_last", int'(frame_last), 0);
    chk("mrst_ready", int'(in_ready), 1);
    chk("mrst_lfsr", int'(dut.lfsr_q), 1);
    repeat (3) @(negedge clock);
    chk("mrst_hold_valid", int'(bit_valid), 0);
    reset_n = 1'b1;
    send(100, 100);
    chk("v100_bit0", int'(bit_out), 1);
    wait_last("v100");
    after_frame("v100");

    // Two contiguous 2048 frames; LFSR must cover the whole period.
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 13'(2048);
    exp_q.push_back(2048);
    exp_q.push_back(2048);
    @(posedge clock);
    #1;
    for (int i = 0; i < FRAME; i++) seen[i] = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clock);
      if (bit_valid === 1'b1) seen[int'(dut.lfsr_q)] = 1'b1;
    end
    chk("h_last_seen", int'(frame_last), 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("h_contig_first", int'(frame_first), 1);
    distinct = 0;
    for (int i = 0; i < FRAME; i++) if (seen[i]) distinct++;
    chk("lfsr_coverage", distinct, FRAME);
    wait_last("h2");
    after_frame("h2");

    repeat (5) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    chk("idle_outputs", idle_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
